// File: rtl/conway_vga_pkg.sv
// conway_vga_pkg: shared timing defaults, colour constants and rgb_t.
// No ports; imported by vga_timing and conway_vga_render.
package conway_vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_CELL_PX  = 15;
  localparam int DEF_X_OFFSET = 80;
  localparam int DEF_GEN_DIV  = 8;
  localparam int GRID_N       = 32;

  localparam int H_TOTAL =
    DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL =
    DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int HS_END   = HS_START + DEF_H_SYNC - 1;
  localparam int VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int VS_END   = VS_START + DEF_V_SYNC - 1;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t COL_LIVE   = 12'hFFF;
  localparam rgb_t COL_DEAD   = 12'h000;
  localparam rgb_t COL_BORDER = 12'h004;
  localparam rgb_t COL_LINE   = 12'h222;

endpackage

// File: rtl/vga_timing.sv
// vga_timing: h/v counters, sync decode and active flag (stage 0).
// in clk, reset; out h_cnt, v_cnt, h_last, v_last, v_act, active, hsync_c, vsync_c
module vga_timing
  import conway_vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
)(
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       h_last,
  output logic       v_last,
  output logic       v_act,
  output logic       active,
  output logic       hsync_c,
  output logic       vsync_c
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_END = 10'(HT - 1);
  localparam logic [9:0] V_END = 10'(VT - 1);
  localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
  localparam logic [9:0] HS_A  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_B  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_A  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_B  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  assign h_last = (h_cnt == H_END);
  assign v_last = (v_cnt == V_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  assign v_act   = (v_cnt < V_ACT);
  assign active  = (h_cnt < H_ACT) && v_act;
  assign hsync_c = !((h_cnt >= HS_A) && (h_cnt <= HS_B));
  assign vsync_c = !((v_cnt >= VS_A) && (v_cnt <= VS_B));

endmodule

// File: rtl/conway_vga_render.sv
// conway_vga_render: 640x480 VGA view of a 32x32 Life grid, frame snapshot, gen divider.
// in clk, reset, grid_pack[1023:0]; out hsync, vsync, vga_r/g/b, frame_tick, gen_tick. Option: CONWAY_VGA_GRID_LINES_EN
module conway_vga_render
  import conway_vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CELL_PX  = DEF_CELL_PX,
  parameter int X_OFFSET = DEF_X_OFFSET,
  parameter int GEN_DIV  = DEF_GEN_DIV
)(
  input  logic          clk,
  input  logic          reset,
  input  logic [1023:0] grid_pack,
  output logic          hsync,
  output logic          vsync,
  output logic [3:0]    vga_r,
  output logic [3:0]    vga_g,
  output logic [3:0]    vga_b,
  output logic          frame_tick,
  output logic          gen_tick
);

  localparam logic [9:0] X_LO  = 10'(X_OFFSET);
  localparam logic [9:0] X_HI  = 10'(X_OFFSET + GRID_N * CELL_PX);
  localparam logic [9:0] X_PRE = 10'(X_OFFSET - 1);
  localparam logic [9:0] V_SNP = 10'(V_ACTIVE);
  localparam logic [3:0] S_END = 4'(CELL_PX - 1);
  localparam logic [7:0] F_END = 8'(GEN_DIV - 1);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_last;
  logic       v_last;
  logic       v_act;
  logic       active;
  logic       hs_c;
  logic       vs_c;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk     (clk),
    .reset   (reset),
    .h_cnt   (h_cnt),
    .v_cnt   (v_cnt),
    .h_last  (h_last),
    .v_last  (v_last),
    .v_act   (v_act),
    .active  (active),
    .hsync_c (hs_c),
    .vsync_c (vs_c)
  );

  logic [1023:0] snap;
  logic [7:0]    frame_cnt;
  logic [3:0]    sub_x;
  logic [3:0]    sub_y;
  logic [4:0]    col;
  logic [4:0]    row;
  logic          snap_pt;
  logic          border;
  logic          live;
  rgb_t          pix;
  rgb_t          rgb;

  assign snap_pt = (h_cnt == '0) && (v_cnt == V_SNP);

  always_ff @(posedge clk) begin
    if (reset) begin
      snap      <= '0;
      frame_cnt <= '0;
    end else if (snap_pt) begin
      snap      <= grid_pack;
      frame_cnt <= (frame_cnt == F_END) ? '0 : frame_cnt + 8'd1;
    end
  end

  // Cell counters track the current h_cnt/v_cnt: cleared one
  // cycle ahead so they read zero at the field's first pixel/line.
  always_ff @(posedge clk) begin
    if (reset) begin
      sub_x <= '0;
      col   <= '0;
    end else if (h_cnt == X_PRE) begin
      sub_x <= '0;
      col   <= '0;
    end else if (sub_x == S_END) begin
      sub_x <= '0;
      col   <= col + 5'd1;
    end else begin
      sub_x <= sub_x + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sub_y <= '0;
      row   <= '0;
    end else if (h_last && v_last) begin
      sub_y <= '0;
      row   <= '0;
    end else if (h_last && v_act) begin
      if (sub_y == S_END) begin
        sub_y <= '0;
        row   <= row + 5'd1;
      end else begin
        sub_y <= sub_y + 4'd1;
      end
    end
  end

  assign border = (h_cnt < X_LO) || (h_cnt >= X_HI);
  // Screen row 0 is the top, which shows grid row 31.
  assign live   = snap[{~row, col}];

  always_comb begin
    pix = '0;
    if (!active)
      pix = '0;
    else if (border)
      pix = COL_BORDER;
    else if (live)
      pix = COL_LIVE;
`ifdef CONWAY_VGA_GRID_LINES_EN
    else if (sub_x == '0 || sub_y == '0)
      pix = COL_LINE;
`endif
    else
      pix = COL_DEAD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      rgb        <= '0;
      frame_tick <= 1'b0;
      gen_tick   <= 1'b0;
    end else begin
      hsync      <= hs_c;
      vsync      <= vs_c;
      rgb        <= pix;
      frame_tick <= snap_pt;
      gen_tick   <= snap_pt && (frame_cnt == F_END);
    end
  end

  assign vga_r = rgb.r;
  assign vga_g = rgb.g;
  assign vga_b = rgb.b;

endmodule

// File: tb/tb_conway_vga_render.sv
// tb_conway_vga_render: directed checks of a full-size and a scaled renderer.
// d0 uses default 640x480 timing; d1 is a shrunk 76x67 raster with GEN_DIV=3.
module tb_conway_vga_render;

`ifdef CONWAY_VGA_GRID_LINES_EN
  localparam logic [11:0] LAT = 12'h222;
`else
  localparam logic [11:0] LAT = 12'h000;
`endif

  localparam int F1 = 76 * 67;
  localparam int A1 = 64 * 76;
  localparam int TMO = 200000;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic          reset0, reset1;
  logic [1023:0] grid0, grid1;
  logic          hs0, vs0, ft0, gt0;
  logic          hs1, vs1, ft1, gt1;
  logic [3:0]    r0, g0, b0, r1, g1, b1;
  logic [11:0]   rgb0, rgb1;
  logic [1023:0] ga, gb;

  assign rgb0 = {r0, g0, b0};
  assign rgb1 = {r1, g1, b1};

  conway_vga_render d0 (
    .clk        (clk),
    .reset      (reset0),
    .grid_pack  (grid0),
    .hsync      (hs0),
    .vsync      (vs0),
    .vga_r      (r0),
    .vga_g      (g0),
    .vga_b      (b0),
    .frame_tick (ft0),
    .gen_tick   (gt0)
  );

  conway_vga_render #(
    .H_ACTIVE (72), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (64), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .CELL_PX  (2),  .X_OFFSET (4), .GEN_DIV (3)
  ) d1 (
    .clk        (clk),
    .reset      (reset1),
    .grid_pack  (grid1),
    .hsync      (hs1),
    .vsync      (vs1),
    .vga_r      (r1),
    .vga_g      (g1),
    .vga_b      (b1),
    .frame_tick (ft1),
    .gen_tick   (gt1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs = 0;
  int checks = 0;
  int t0, t1;

  always @(posedge clk) begin
    if (cyc > TMO) begin
      errs++;
      $error("FAIL timeout cyc=%0d", cyc);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
    end
  end

  task automatic chk(
    input string       tag,
    input logic [11:0] obs,
    input logic [11:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errs++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic at(input int base, input int k);
    while (cyc < base + k + 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    ga = '0;
    ga[31*32+0] = 1'b1;
    gb = '0;
    gb[1*32+0] = 1'b1;
    gb[31*32+31] = 1'b1;
    reset0 = 1'b1;
    reset1 = 1'b1;
    grid0 = '0;
    grid1 = ga;
    repeat (2) @(posedge clk);
    #1;
    t0 = cyc;
    reset0 = 1'b0;
    reset1 = 1'b0;

    chk("rst_hs0", hs0, 1'b1);
    chk("rst_vs0", vs0, 1'b1);
    chk("rst_rgb0", rgb0, 12'h000);
    chk("rst_ft0", ft0, 1'b0);
    chk("rst_gt0", gt0, 1'b0);
    chk("rst_hs1", hs1, 1'b1);
    chk("rst_rgb1", rgb1, 12'h000);

    at(t0, 72);   chk("d1_hs_pre", hs1, 1'b1);
    at(t0, 73);   chk("d1_hs_lo", hs1, 1'b0);
    at(t0, 75);   chk("d1_hs_post", hs1, 1'b1);
    at(t0, 79);   chk("d1_f0_border", rgb1, 12'h004);
    at(t0, 81);   chk("d1_f0_nosnap", rgb1, 12'h000);

    at(t0, 655);  chk("d0_hs_655", hs0, 1'b1);
    at(t0, 656);  chk("d0_hs_656", hs0, 1'b0);
    at(t0, 751);  chk("d0_hs_751", hs0, 1'b0);
    at(t0, 752);  chk("d0_hs_752", hs0, 1'b1);
    at(t0, 801);  chk("d0_x1y1", rgb0, 12'h004);
    at(t0, 881);  chk("d0_x81y1", rgb0, 12'h000);
    at(t0, 1455); chk("d0_hs_l1_pre", hs0, 1'b1);
    at(t0, 1456); chk("d0_hs_l1_lo", hs0, 1'b0);
    at(t0, 1551); chk("d0_hs_l1_end", hs0, 1'b0);
    at(t0, 1552); chk("d0_hs_l1_post", hs0, 1'b1);
    at(t0, 1600); chk("d0_x0", rgb0, 12'h004);
    at(t0, 1679); chk("d0_x79", rgb0, 12'h004);
    at(t0, 1680); chk("d0_x80", rgb0, LAT);
    at(t0, 1681); chk("d0_x81", rgb0, 12'h000);
    at(t0, 1695); chk("d0_x95", rgb0, LAT);
    at(t0, 1710); chk("d0_x110", rgb0, LAT);
    at(t0, 2159); chk("d0_x559", rgb0, 12'h000);
    at(t0, 2160); chk("d0_x560", rgb0, 12'h004);
    at(t0, 2239); chk("d0_x639", rgb0, 12'h004);
    at(t0, 2240); chk("d0_x640", rgb0, 12'h000);
    chk("d0_vs_idle", vs0, 1'b1);

    at(t0, A1 - 1); chk("d1_ft_pre", ft1, 1'b0);
    at(t0, A1);     chk("d1_ft1", ft1, 1'b1);
    chk("d1_gt1", gt1, 1'b0);
    at(t0, A1 + 1); chk("d1_ft_post", ft1, 1'b0);
    at(t0, 4939);   chk("d1_vs_pre", vs1, 1'b1);
    at(t0, 4940);   chk("d1_vs_lo", vs1, 1'b0);
    at(t0, 5015);   chk("d1_vs_end", vs1, 1'b0);
    at(t0, 5016);   chk("d1_vs_post", vs1, 1'b1);

    at(t0, F1 + 4);   chk("d1_f1_x4y0", rgb1, 12'hFFF);
    at(t0, F1 + 79);  chk("d1_f1_x3y1", rgb1, 12'h004);
    at(t0, F1 + 81);  chk("d1_f1_x5y1", rgb1, 12'hFFF);
    at(t0, F1 + 83);  chk("d1_f1_x7y1", rgb1, 12'h000);
    at(t0, F1 + 143); chk("d1_f1_x67y1", rgb1, 12'h000);
    at(t0, F1 + 144); chk("d1_f1_x68y1", rgb1, 12'h004);
    at(t0, F1 + 233); chk("d1_f1_x5y3", rgb1, 12'h000);

    at(t0, F1 + 40 * 76);
    grid1 = gb;
    at(t0, F1 + 4641); chk("d1_f1_nochg", rgb1, 12'h000);
    at(t0, A1 + F1);   chk("d1_ft2", ft1, 1'b1);
    chk("d1_gt2", gt1, 1'b0);
    at(t0, 2 * F1 + 81);   chk("d1_f2_x5y1", rgb1, 12'h000);
    at(t0, 2 * F1 + 143);  chk("d1_f2_x67y1", rgb1, 12'hFFF);
    at(t0, 2 * F1 + 144);  chk("d1_f2_x68y1", rgb1, 12'h004);
    at(t0, 2 * F1 + 4641); chk("d1_f2_x5y61", rgb1, 12'hFFF);
    at(t0, A1 + 2 * F1);   chk("d1_ft3", ft1, 1'b1);
    chk("d1_gt3", gt1, 1'b1);
    at(t0, A1 + 2 * F1 + 1); chk("d1_gt3_post", gt1, 1'b0);
    at(t0, A1 + 3 * F1);   chk("d1_ft4", ft1, 1'b1);
    chk("d1_gt4", gt1, 1'b0);

    at(t0, 4 * F1 + 30 * 76 + 40);
    reset1 = 1'b1;
    @(posedge clk);
    #1;
    t1 = cyc;
    reset1 = 1'b0;
    chk("mr_hs", hs1, 1'b1);
    chk("mr_vs", vs1, 1'b1);
    chk("mr_rgb", rgb1, 12'h000);
    chk("mr_ft", ft1, 1'b0);
    chk("mr_gt", gt1, 1'b0);
    at(t1, 73);     chk("mr_hs_lo", hs1, 1'b0);
    at(t1, 4641);   chk("mr_snap0", rgb1, 12'h000);
    at(t1, A1 - 1); chk("mr_ft_pre", ft1, 1'b0);
    at(t1, A1);     chk("mr_ft1", ft1, 1'b1);
    chk("mr_gt1", gt1, 1'b0);
    at(t1, F1 + 4641); chk("mr_f1_x5y61", rgb1, 12'hFFF);
    for (int m = 2; m <= 6; m++) begin
      at(t1, A1 + (m - 1) * F1);
      chk("mr_ft", ft1, 1'b1);
      chk("mr_gt", gt1, (m == 3 || m == 6));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
